// File: rtl/varcic_interp.sv
// varcic_interp: variable-rate CIC interpolator, R in {2,4,5,8,10,20,40}; define VARCIC_INTERP_ROUND_EN for a rounded, saturating output
module varcic_interp #(
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [5:0]                  interpolation,
  input  logic                        out_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        in_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid
);
  localparam logic signed [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  logic [5:0] phase, r_lat, r_eff, phase_nxt;
  logic [6:0] phase_inc;
  logic tick0;
  logic [4:0] growth;
  logic [7:0] shift;
  logic signed [ACC_WIDTH-1:0] comb_q  [STAGES];
  logic signed [ACC_WIDTH-1:0] dly_q   [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_in [STAGES];
  logic signed [ACC_WIDTH-1:0] integ_q [STAGES];
  logic signed [OUT_WIDTH-1:0] slice, out_nxt;
`ifdef VARCIC_INTERP_ROUND_EN
  logic rbit;
`endif
  // phase-0 detection; the ratio latched on this very tick already sets this period's length
  always_comb begin
    tick0 = out_strobe && (phase == 6'd0);
    r_eff = tick0 ? interpolation : r_lat;
    phase_inc = {1'b0, phase} + 7'd1;
    phase_nxt = (phase_inc >= {1'b0, r_eff}) ? 6'd0 : phase_inc[5:0];
  end
  // per-ratio bit growth selects the output slice; unsupported ratios give zero growth and a zero output
  always_comb begin
    growth = (r_lat == 6'd2)  ? 5'd4  :
             (r_lat == 6'd4)  ? 5'd8  :
             (r_lat == 6'd5)  ? 5'd10 :
             (r_lat == 6'd8)  ? 5'd12 :
             (r_lat == 6'd10) ? 5'd14 :
             (r_lat == 6'd20) ? 5'd18 :
             (r_lat == 6'd40) ? 5'd22 : 5'd0;
    shift = 8'(IN_WIDTH - OUT_WIDTH) + 8'(growth);
    slice = OUT_WIDTH'(integ_q[STAGES-1] >>> shift);
`ifdef VARCIC_INTERP_ROUND_EN
    rbit = 1'(integ_q[STAGES-1] >>> (shift - 8'd1));
    out_nxt = (growth == 5'd0) ? '0 : (slice == MAX_POS) ? slice : slice + OUT_WIDTH'(rbit);
`else
    out_nxt = (growth == 5'd0) ? '0 : slice;
`endif
  end
  // comb stage inputs: sign-extended sample into stage 0, each later stage fed by its predecessor
  always_comb begin
    comb_in[0] = ACC_WIDTH'(in_data);
    for (int i = 1; i < STAGES; i++) comb_in[i] = comb_q[i-1];
  end
  // pacing, handshake pulses and the registered output sample
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      r_lat <= '0;
      in_strobe <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      in_strobe <= tick0;
      out_valid <= out_strobe;
      if (out_strobe) phase <= phase_nxt;
      if (out_strobe) out_data <= out_nxt;
      if (tick0) r_lat <= interpolation;
    end
  end
  // comb section runs at the low rate, advancing only on phase-0 ticks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        comb_q[i] <= '0;
        dly_q[i] <= '0;
      end
    end else if (tick0) begin
      for (int i = 0; i < STAGES; i++) begin
        comb_q[i] <= comb_in[i] - dly_q[i];
        dly_q[i] <= comb_in[i];
      end
    end
  end
  // integrators run at the high rate on zero-stuffed input; wrap-around is intended
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) integ_q[i] <= '0;
    end else if (out_strobe) begin
      integ_q[0] <= integ_q[0] + (tick0 ? comb_q[STAGES-1] : '0);
      for (int i = 1; i < STAGES; i++) integ_q[i] <= integ_q[i] + integ_q[i-1];
    end
  end
endmodule

// File: tb/tb_varcic_interp.sv
// tb_varcic_interp: randomized and directed bench for varcic_interp against a sequence-level CIC model
module tb_varcic_interp;
  localparam int S = 5, IW = 16, AW = 40, OW = 16;
  logic clock = 1'b0, reset_n = 1'b0, out_strobe = 1'b0;
  logic [5:0] interpolation = '0;
  logic signed [IW-1:0] in_data = '0;
  logic in_strobe, out_valid;
  logic signed [OW-1:0] out_data;
  int errors = 0, checks = 0;
  logic last_ins = 1'b0;
  logic signed [OW-1:0] last_od = '0;
  logic signed [AW-1:0] xq[$], yq[$];
  logic signed [AW-1:0] acc[S];
  int left;
  logic [5:0] r_cur;
  logic exp_ins, exp_ov;
  logic signed [OW-1:0] exp_od;

  always #5 clock = ~clock;

  varcic_interp #(.STAGES(S), .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clock(clock), .reset_n(reset_n), .interpolation(interpolation), .out_strobe(out_strobe),
    .in_data(in_data), .in_strobe(in_strobe), .out_data(out_data), .out_valid(out_valid)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int growth(input logic [5:0] r);
    case (r)
      6'd2: return 4;
      6'd4: return 8;
      6'd5: return 10;
      6'd8: return 12;
      6'd10: return 14;
      6'd20: return 18;
      6'd40: return 22;
      default: return -1;
    endcase
  endfunction

  function automatic logic signed [OW-1:0] scale(input logic signed [AW-1:0] y, input logic [5:0] r);
    int g, lo;
    logic signed [OW-1:0] s;
    g = growth(r);
    if (g < 0) return '0;
    lo = IW + g - OW;
    s = OW'(y >>> lo);
`ifdef VARCIC_INTERP_ROUND_EN
    if (1'(y >>> (lo - 1)) && s != OW'((1 << (OW - 1)) - 1)) s = s + 1'b1;
`endif
    return s;
  endfunction

  task automatic model_reset();
    xq = {};
    repeat (2 * S + 1) xq.push_back('0);
    yq = {};
    repeat (S) yq.push_back('0);
    for (int i = 0; i < S; i++) acc[i] = '0;
    left = 0;
    r_cur = '0;
    exp_ins = 1'b0;
    exp_ov = 1'b0;
    exp_od = '0;
  endtask

  // xq holds x(t-2S)..x(t); the integrators see the S-th difference delayed by S ticks, and the output lags the integrator cascade by S strobes
  task automatic model_strobe();
    logic signed [AW-1:0] u;
    int c;
    exp_ov = 1'b1;
    exp_od = scale(yq.pop_front(), r_cur);
    u = '0;
    if (left == 0) begin
      r_cur = interpolation;
      left = (r_cur == 6'd0) ? 1 : int'(r_cur);
      exp_ins = 1'b1;
      xq.push_back(AW'(in_data));
      void'(xq.pop_front());
      for (int i = 0; i <= S; i++) begin
        c = (i % 2 == 1) ? -binom(S, i) : binom(S, i);
        u += AW'(c) * xq[S - i];
      end
    end
    left--;
    acc[0] += u;
    for (int i = 1; i < S; i++) acc[i] += acc[i-1];
    yq.push_back(acc[S-1]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      if (!reset_n) model_reset();
      else begin
        exp_ins = 1'b0;
        exp_ov = 1'b0;
        if (out_strobe) model_strobe();
      end
      #1;
      check("in_strobe", in_strobe, exp_ins);
      check("out_valid", out_valid, exp_ov);
      check("out_data", out_data, exp_od);
    end
  end

  task automatic strobe(input int gap);
    out_strobe = 1'b1;
    @(negedge clock);
    out_strobe = 1'b0;
    last_ins = in_strobe;
    last_od = out_data;
    repeat (gap - 1) @(negedge clock);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic run(input int n, input int gap, output int ins_cnt);
    ins_cnt = 0;
    repeat (n) begin
      strobe(gap);
      ins_cnt += int'(last_ins);
    end
  endtask

  initial begin
    int n, nz;
    int rl[12] = '{0, 1, 2, 3, 4, 5, 7, 8, 10, 20, 40, 63};
    @(negedge clock);
    interpolation = 6'd8;
    in_data = 16'sd1000;
    repeat (3) begin
      strobe(2);
      check("rst_in_strobe", last_ins, 0);
      check("rst_out_data", last_od, 0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    strobe(2);
    check("first_in_strobe", last_ins, 1);

    restart();
    strobe(4);
    check("pace_first", last_ins, 1);
    run(7, 4, n);
    check("pace_idle", n, 0);
    strobe(4);
    check("pace_second", last_ins, 1);
    run(16, 4, n);
    check("pace_count", n, 2);

    restart();
    run(128, 2, n);
    check("dc_r8", last_od, 1000);
    restart();
    interpolation = 6'd4;
    run(64, 2, n);
    check("dc_r4", last_od, 1000);
    restart();
    interpolation = 6'd5;
    run(80, 2, n);
    check("dc_r5_near_610", (last_od >= 609 && last_od <= 611), 1);

    restart();
    in_data = 16'sd32767;
    interpolation = 6'd8;
    run(96, 2, n);
    run(4, 2, n);
    interpolation = 6'd40;
    run(4, 2, n);
    check("change_completes", n, 0);
    strobe(2);
    check("change_new_tick", last_ins, 1);
    run(39, 2, n);
    check("change_long_idle", n, 0);
    strobe(2);
    check("change_next_tick", last_ins, 1);
    run(400, 2, n);
    check("change_no_wrap", last_od >= 0, 1);

    restart();
    run(560, 2, n);
    check("dc_r40_full_scale", (last_od >= 19998 && last_od <= 20000), 1);

    restart();
    interpolation = 6'd3;
    in_data = 16'sd500;
    n = 0;
    nz = 0;
    repeat (30) begin
      strobe(2);
      n += int'(last_ins);
      nz += int'(last_od != 0);
    end
    check("r3_in_strobes", n, 10);
    check("r3_zero_out", nz, 0);
    in_data = '0;
    run(60, 2, n);
    interpolation = 6'd2;
    in_data = 16'sd1000;
    run(40, 2, n);
    check("r3_to_r2_restore", last_od, 1000);

    restart();
    repeat (2500) begin
      if ($urandom_range(0, 99) < 3) interpolation = 6'(rl[$urandom_range(0, 11)]);
      strobe($urandom_range(2, 4));
      if (last_ins) in_data = IW'($urandom);
      if ($urandom_range(0, 499) == 0) restart();
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
